// File: rtl/lif_soma_array_neuron.sv
// Multi-channel leaky integrate-and-fire soma: saturating signed integration,
// tick-driven leak and refractory period, and a multi-spike axon delay line.
module lif_soma_array_neuron #(
    parameter int W         = 16,
    parameter int IN_CH     = 8,
    parameter int WW        = 8,
    parameter int CNT_W     = 8,
    parameter int MAX_DELAY = 16,
    localparam int DW       = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_load,
    input  logic [W-1:0]        cfg_v_rest,
    input  logic [W-1:0]        cfg_v_th,
    input  logic [W-1:0]        cfg_v_leak,
    input  logic [CNT_W-1:0]    cfg_refr,
    input  logic [DW-1:0]       cfg_delay,
    input  logic                kill,
    input  logic                tick,
    input  logic [IN_CH-1:0]    in_valid,
    input  logic [IN_CH*WW-1:0] in_weight,
    output logic                out_spike,
    output logic                o_wait,
    output logic [1:0]          o_state,
    output logic [W-1:0]        o_potential
);
    localparam int SW = W + $clog2(IN_CH) + 2;
    localparam logic signed [SW-1:0] V_MAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [DW-1:0] DELAY_MAX = DW'(MAX_DELAY - 1);

    typedef enum logic [1:0] {
        DEACTIVE   = 2'b00,
        ACTIVE     = 2'b01,
        ILLEGAL    = 2'b10,
        REFRACTORY = 2'b11
    } state_t;

    state_t                r_state, w_stateNext;
    logic signed [W-1:0]   r_vRest, r_vTh, r_v, w_vNext, w_vSat;
    logic [W-1:0]          r_vLeak;
    logic [CNT_W-1:0]      r_refr, r_refrCnt, w_cntNext;
    logic [DW-1:0]         r_delay, w_delayClamped;
    logic [MAX_DELAY-1:0]  r_delayLine;
    logic                  r_outSpike;
    logic signed [SW-1:0]  w_sum, w_vExt, w_restExt, w_leak, w_vSum;
    logic                  w_fire, w_inject, w_cfgLatch;

    // Wide datapath: sum of active weights, leak, then saturate high and clamp at rest.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < IN_CH; i++) begin
            if (in_valid[i]) begin
                w_sum = w_sum + {{(SW-WW){in_weight[i*WW+WW-1]}}, in_weight[i*WW +: WW]};
            end
        end
        w_vExt    = {{(SW-W){r_v[W-1]}}, r_v};
        w_restExt = {{(SW-W){r_vRest[W-1]}}, r_vRest};
        w_leak    = tick ? {{(SW-W){1'b0}}, r_vLeak} : '0;
        w_vSum    = w_vExt + w_sum - w_leak;
        if (w_vSum > V_MAX) begin
            w_vSat = V_MAX[W-1:0];
        end else if (w_vSum < w_restExt) begin
            w_vSat = r_vRest;
        end else begin
            w_vSat = w_vSum[W-1:0];
        end
        w_fire = (w_vSat >= r_vTh);
    end

    assign w_delayClamped = (cfg_delay > DELAY_MAX) ? DELAY_MAX : cfg_delay;

    always_comb begin
        w_stateNext = r_state;
        w_vNext     = r_v;
        w_cntNext   = r_refrCnt;
        w_inject    = 1'b0;
        w_cfgLatch  = 1'b0;
        if (kill) begin
            w_stateNext = DEACTIVE;
            w_vNext     = r_vRest;
            w_cntNext   = '0;
        end else begin
            case (r_state)
                DEACTIVE: begin
                    if (cfg_load) begin
                        w_cfgLatch  = 1'b1;
                        w_vNext     = cfg_v_rest;
                        w_stateNext = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_fire) begin
                        w_vNext   = r_vRest;
                        w_inject  = 1'b1;
                        w_cntNext = r_refr;
                        if (r_refr != '0) begin
                            w_stateNext = REFRACTORY;
                        end
                    end else begin
                        w_vNext = w_vSat;
                    end
                end
                REFRACTORY: begin
                    w_vNext = r_vRest;
                    // A zero count can only appear through corruption; treat it as expired.
                    if (tick) begin
                        if (r_refrCnt <= CNT_W'(1)) begin
                            w_cntNext   = '0;
                            w_stateNext = ACTIVE;
                        end else begin
                            w_cntNext = r_refrCnt - CNT_W'(1);
                        end
                    end
                end
                default: w_stateNext = DEACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DEACTIVE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vRest     <= '0;
            r_vTh       <= '0;
            r_vLeak     <= '0;
            r_refr      <= '0;
            r_delay     <= '0;
            r_v         <= '0;
            r_refrCnt   <= '0;
            r_delayLine <= '0;
            r_outSpike  <= 1'b0;
        end else begin
            if (w_cfgLatch) begin
                r_vRest <= cfg_v_rest;
                r_vTh   <= cfg_v_th;
                r_vLeak <= cfg_v_leak;
                r_refr  <= cfg_refr;
                r_delay <= w_delayClamped;
            end
            r_v       <= w_vNext;
            r_refrCnt <= w_cntNext;
            if (kill) begin
                r_delayLine <= '0;
                r_outSpike  <= 1'b0;
            end else begin
                r_delayLine <= (r_delayLine << 1) | MAX_DELAY'(w_inject);
                r_outSpike  <= r_delayLine[r_delay];
            end
        end
    end

    assign out_spike   = r_outSpike;
    assign o_wait      = (r_state == REFRACTORY);
    assign o_state     = r_state;
    assign o_potential = r_v;

endmodule

// File: doc/lif_soma_array_neuron.md
Name: lif_soma_array_neuron

Overview:
- Parametrised leaky integrate-and-fire soma with IN_CH synaptic input channels, signed weights, a programmable refractory counter and a multi-spike axon delay line.
- Sits between the synapse/weight fetch stage and the spike router.
- Successor of the single-input soma:
  - configurable widths and channel count;
  - explicit parameter load;
  - saturating arithmetic;
  - tick-based leak and refractory timing;
  - pipelined axon delay that can hold several spikes in flight.

Parameters:
- W, 16, membrane potential and threshold width (signed two's complement).
- IN_CH, 8, number of synaptic input channels.
- WW, 8, per-channel weight width (signed).
- CNT_W, 8, refractory counter width.
- MAX_DELAY, 16, axon delay line depth in clk cycles (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_load  in  1  load configuration; honoured only in DEACTIVE.
- cfg_v_rest  in  W  resting/reset potential (signed).
- cfg_v_th  in  W  firing threshold (signed).
- cfg_v_leak  in  W  leak subtracted per tick (unsigned magnitude).
- cfg_refr  in  CNT_W  refractory length in ticks.
- cfg_delay  in  $clog2(MAX_DELAY)  axon delay in clk cycles.
- kill  in  1  force DEACTIVE.
- tick  in  1  time-step strobe; applies leak and advances the refractory count.
- in_valid  in  IN_CH  per-channel spike-valid.
- in_weight  in  IN_CH*WW  packed signed weights; channel i at [i*WW +: WW].
- out_spike  out  1  delayed output spike pulse (1 clk).
- o_wait  out  1  high while REFRACTORY.
- o_state  out  2  current state.
- o_potential  out  W  current membrane potential.

Behaviour:
- States:
  - DEACTIVE=2'b00.
  - ACTIVE=2'b01.
  - REFRACTORY=2'b11.
  - 2'b10 is illegal: it recovers to DEACTIVE on the next clk.
- Reset (rst=0, async): state DEACTIVE; all config registers 0; V=0; refractory counter 0; delay line cleared. Outputs: out_spike=0, o_wait=0, o_state=00, o_potential=0.
- DEACTIVE:
  - Inputs and tick are ignored.
  - cfg_load=1 latches all cfg_* inputs, sets V=cfg_v_rest and moves to ACTIVE on the same edge.
  - cfg_load is ignored in every other state.
- kill=1 has highest priority in any state:
  - next state is DEACTIVE;
  - V=config v_rest;
  - refractory counter is cleared;
  - delay line is cleared, so in-flight spikes are dropped;
  - configuration is retained.
- ACTIVE, each clk:
  - S = sign-extended sum of in_weight[i] over all i with in_valid[i]=1.
  - L = v_leak if tick=1, else 0.
  - Vn = V + S - L, computed at width W+$clog2(IN_CH)+2.
  - Vn saturates to the signed W-bit maximum on overflow.
  - If Vn < v_rest, Vn is clamped to v_rest.
  - Fire when Vn >= v_th:
    - V <= v_rest;
    - a 1 is injected into the delay line;
    - refractory counter <= cfg_refr;
    - next state is REFRACTORY if cfg_refr != 0, otherwise stay ACTIVE.
  - Otherwise V <= Vn.
- REFRACTORY:
  - Inputs are ignored and V is held at v_rest.
  - On tick, the counter decrements.
  - On a tick where counter==1, the counter goes to 0 and the next state is ACTIVE.
  - Integration resumes on the following clk.
  - o_wait=1 only in this state (registered from state).
- Axon delay line:
  - Shift register of MAX_DELAY bits, advanced every clk in every state except during kill or reset.
  - out_spike is registered and is high for exactly one clk, cfg_delay+1 clk edges after the firing edge.
  - cfg_delay values >= MAX_DELAY are clamped to MAX_DELAY-1.
  - Multiple spikes in flight are preserved in order, with no merging or loss.
- Simultaneous tick and input in ACTIVE: weights and leak are applied in the same Vn computation.
- Reset mid-operation: everything returns to reset values asynchronously; a new cfg_load is required.

Test Plan:
- Reset, then cfg_load with v_rest=10, v_th=50, leak=2, refr=3, delay=2 -> o_state=01, o_potential=10, out_spike=0.
- ACTIVE, in_valid=4'b0011 with weights 20 and 25 for one clk, no tick -> potential returns to 10, o_state=11, o_wait=1; out_spike is high exactly 3 clk edges after the fire edge.
- In REFRACTORY, issue 3 tick pulses while in_valid is high with weight 100 -> no fire; ACTIVE after the 3rd tick; potential stays 10 throughout.
- ACTIVE, weight -30 on ch0, then a tick with leak=2 at V=10 -> V clamps to 10; weights 127 on 4 channels from V near max -> saturates, fires, no wraparound.
- refr=0, delay=5, fire on 3 consecutive clks -> stays ACTIVE; out_spike is high on 3 consecutive clks starting 6 edges after the first fire.
- kill asserted with 2 spikes in flight while REFRACTORY -> DEACTIVE next edge, no out_spike afterwards; cfg_load returns to ACTIVE with potential=v_rest.
